// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game-control layer: FSM state encoding and
// the upper bound on the number of players.
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int unsigned MAX_PLAYERS = 8;
    localparam int unsigned STATE_W     = 3;

    // Codes 4..7 are unused and treated as illegal by the sequencer
    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        TURN      = 3'd1,
        RESOLVE   = 3'd2,
        GAME_OVER = 3'd3
    } game_state_t;

endpackage

// File: rtl/next_alive_picker.sv
// ---------------------------------------------------------------------------
// next_alive_picker
// Combinational round-robin search: finds the first alive player after
// 'cur', wrapping modulo N and never returning 'cur' itself.
//
// Parameters:
//   N           number of players
// Ports:
//   alive       in   N    per-player alive mask
//   cur         in   PW   index of the current player
//   next_idx_c  out  PW   next alive index (equals cur when none found)
//   found_c     out  1    high when another alive player exists
// ---------------------------------------------------------------------------
module next_alive_picker #(
    parameter  int unsigned N  = 2,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  alive,
    input  logic [PW-1:0] cur,
    output logic [PW-1:0] next_idx_c,
    output logic          found_c
);

    // Walk offsets 1..N-1 so the nearest alive successor wins
    always_comb begin
        logic [PW-1:0] idx;
        next_idx_c = cur;
        found_c    = 1'b0;
        idx        = '0;
        for (int unsigned k = 1; k < N; k++) begin
            idx = PW'((32'(cur) + k) % N);
            if (!found_c && alive[idx]) begin
                found_c    = 1'b1;
                next_idx_c = idx;
            end
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// ---------------------------------------------------------------------------
// turn_sequencer
// N-player round-robin turn controller. Starts a game on enter, hands the
// turn to the next alive player on turn_done, skips players whose HP is 0
// and declares a winner (or a draw) once at most one player is left.
//
// Optional feature: define TURN_TIMEOUT_EN to forfeit a turn that lasts
// TURN_TIMEOUT cycles. Without it there is no timer and timeout_pulse = 0.
//
// Parameters:
//   N_PLAYERS     number of players (2..8)
//   HP_W          width of one player's HP value
//   TURN_TIMEOUT  cycles allowed per turn (TURN_TIMEOUT_EN only)
// Ports:
//   clk             in   1             system clock
//   rst             in   1             asynchronous active-high reset
//   enter_pressed   in   N_PLAYERS     one-cycle enter pulse per player
//   turn_done       in   N_PLAYERS     one-cycle end-of-turn pulse per player
//   hp              in   N*HP_W        packed HP, player i at [i*HP_W +: HP_W]
//   turn_onehot     out  N_PLAYERS     active player, zero outside TURN
//   active_player   out  PW            current / last active player
//   state_game_fsm  out  3             FSM state code
//   start_game      out  1             high from game start until IDLE
//   winner          out  PW            surviving player index
//   winner_valid    out  1             exactly one survivor in GAME_OVER
//   timeout_pulse   out  1             one-cycle pulse on forfeit
// ---------------------------------------------------------------------------
module turn_sequencer
    import game_pkg::*;
#(
    parameter  int unsigned N_PLAYERS    = 2,
    parameter  int unsigned HP_W         = 10,
    parameter  int unsigned TURN_TIMEOUT = 1000000,
    localparam int unsigned PW           = $clog2(N_PLAYERS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PLAYERS-1:0]      enter_pressed,
    input  logic [N_PLAYERS-1:0]      turn_done,
    input  logic [N_PLAYERS*HP_W-1:0] hp,
    output logic [N_PLAYERS-1:0]      turn_onehot,
    output logic [PW-1:0]             active_player,
    output logic [2:0]                state_game_fsm,
    output logic                      start_game,
    output logic [PW-1:0]             winner,
    output logic                      winner_valid,
    output logic                      timeout_pulse
);

    localparam int unsigned CW = $clog2(N_PLAYERS + 1);

    localparam logic [STATE_W-1:0] S_IDLE      = 3'(IDLE);
    localparam logic [STATE_W-1:0] S_TURN      = 3'(TURN);
    localparam logic [STATE_W-1:0] S_RESOLVE   = 3'(RESOLVE);
    localparam logic [STATE_W-1:0] S_GAME_OVER = 3'(GAME_OVER);

    // Reject out-of-range configurations at elaboration time
    if (N_PLAYERS < 2 || N_PLAYERS > MAX_PLAYERS || TURN_TIMEOUT < 2) begin : g_bad_params
        $error("turn_sequencer: unsupported N_PLAYERS or TURN_TIMEOUT");
    end

    logic [STATE_W-1:0]   state;
    logic [STATE_W-1:0]   state_n;
    logic [N_PLAYERS-1:0] onehot_n;
    logic [PW-1:0]        active_n;
    logic                 start_n;
    logic [PW-1:0]        winner_n;
    logic                 wvalid_n;

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TURN_TIMEOUT + 1);
    logic [TW-1:0]        timer;
    logic [TW-1:0]        timer_n;
    logic                 tpulse_n;
`endif

    logic [N_PLAYERS-1:0] alive;
    logic [CW-1:0]        alive_cnt;
    logic [N_PLAYERS-1:0] enter_cand;
    logic [PW-1:0]        enter_idx;
    logic                 enter_hit;
    logic [PW-1:0]        sole_idx;
    logic [PW-1:0]        pick_idx;
    logic                 pick_found;
    logic                 active_alive;
    logic                 active_done;

    // A player is alive while its HP slice is non-zero
    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_alive
        assign alive[g] = |hp[g*HP_W +: HP_W];
    end

    assign alive_cnt      = CW'($countones(alive));
    assign enter_cand     = enter_pressed & alive;
    assign active_alive   = alive[active_player];
    assign active_done    = turn_done[active_player];
    assign state_game_fsm = state;

    // Lowest-index alive presser, and lowest-index survivor for the winner
    always_comb begin
        logic sole_hit;
        enter_hit = 1'b0;
        enter_idx = '0;
        sole_hit  = 1'b0;
        sole_idx  = '0;
        for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            if (!enter_hit && enter_cand[PW'(i)]) begin
                enter_hit = 1'b1;
                enter_idx = PW'(i);
            end
            if (!sole_hit && alive[PW'(i)]) begin
                sole_hit = 1'b1;
                sole_idx = PW'(i);
            end
        end
    end

    next_alive_picker #(
        .N          (N_PLAYERS)
    ) u_picker (
        .alive      (alive),
        .cur        (active_player),
        .next_idx_c (pick_idx),
        .found_c    (pick_found)
    );

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        onehot_n = turn_onehot;
        active_n = active_player;
        start_n  = start_game;
        winner_n = winner;
        wvalid_n = winner_valid;
`ifdef TURN_TIMEOUT_EN
        timer_n  = timer;
        tpulse_n = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                if (enter_hit && alive_cnt >= CW'(2)) begin
                    state_n  = S_TURN;
                    active_n = enter_idx;
                    onehot_n = N_PLAYERS'(1) << enter_idx;
                    start_n  = 1'b1;
`ifdef TURN_TIMEOUT_EN
                    timer_n  = '0;
`endif
                end
            end

            S_TURN: begin
                // Elimination outranks turn_done and timeout; a dead
                // active player simply hands over like a finished turn
                if (alive_cnt <= CW'(1)) begin
                    state_n = S_GAME_OVER;
                end else if (!active_alive || active_done) begin
                    state_n  = S_RESOLVE;
                    onehot_n = '0;
`ifdef TURN_TIMEOUT_EN
                end else if (timer == TW'(TURN_TIMEOUT - 1)) begin
                    state_n  = S_RESOLVE;
                    onehot_n = '0;
                    tpulse_n = 1'b1;
                end else if (timer < TW'(TURN_TIMEOUT)) begin
                    timer_n = timer + TW'(1);
`endif
                end
            end

            S_RESOLVE: begin
                if (alive_cnt <= CW'(1) || !pick_found) begin
                    state_n = S_GAME_OVER;
                end else begin
                    state_n  = S_TURN;
                    active_n = pick_idx;
                    onehot_n = N_PLAYERS'(1) << pick_idx;
`ifdef TURN_TIMEOUT_EN
                    timer_n  = '0;
`endif
                end
            end

            S_GAME_OVER: begin
                if (|enter_pressed) begin
                    state_n  = S_IDLE;
                    start_n  = 1'b0;
                    wvalid_n = 1'b0;
                end
            end

            default: begin
                state_n  = S_IDLE;
                onehot_n = '0;
                active_n = '0;
                start_n  = 1'b0;
                winner_n = '0;
                wvalid_n = 1'b0;
`ifdef TURN_TIMEOUT_EN
                timer_n  = '0;
`endif
            end
        endcase

        // Winner tracks the survivor on entry to and while in GAME_OVER;
        // with nobody left the previous winner index is kept
        if (state_n == S_GAME_OVER) begin
            onehot_n = '0;
            if (alive_cnt == CW'(1)) begin
                winner_n = sole_idx;
                wvalid_n = 1'b1;
            end else begin
                wvalid_n = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            turn_onehot   <= '0;
            active_player <= '0;
            start_game    <= 1'b0;
            winner        <= '0;
            winner_valid  <= 1'b0;
        end else begin
            state         <= state_n;
            turn_onehot   <= onehot_n;
            active_player <= active_n;
            start_game    <= start_n;
            winner        <= winner_n;
            winner_valid  <= wvalid_n;
        end
    end

`ifdef TURN_TIMEOUT_EN
    // Turn timer and forfeit pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer         <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timer         <= timer_n;
            timeout_pulse <= tpulse_n;
        end
    end
`else
    assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_turn_sequencer.sv
// ---------------------------------------------------------------------------
// tb_turn_sequencer
// Directed and randomized checks of turn_sequencer (4 players) against a
// behavioural game model kept in the bench.
// ---------------------------------------------------------------------------
module tb_turn_sequencer;

    localparam int unsigned NP   = 4;
    localparam int unsigned HP_W = 10;
    localparam int unsigned TT   = 16;
    localparam int unsigned PW   = $clog2(NP);

`ifdef TURN_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic [NP-1:0]        enter_pressed;
    logic [NP-1:0]        turn_done;
    logic [NP*HP_W-1:0]   hp;
    logic [NP-1:0]        turn_onehot;
    logic [PW-1:0]        active_player;
    logic [2:0]           state_game_fsm;
    logic                 start_game;
    logic [PW-1:0]        winner;
    logic                 winner_valid;
    logic                 timeout_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: 0 idle, 1 turn, 2 resolve, 3 game over
    int m_state  = 0;
    int m_active = 0;
    int m_start  = 0;
    int m_winner = 0;
    int m_wvalid = 0;
    int m_tpulse = 0;
    int m_timer  = 0;

    turn_sequencer #(
        .N_PLAYERS      (NP),
        .HP_W           (HP_W),
        .TURN_TIMEOUT   (TT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enter_pressed  (enter_pressed),
        .turn_done      (turn_done),
        .hp             (hp),
        .turn_onehot    (turn_onehot),
        .active_player  (active_player),
        .state_game_fsm (state_game_fsm),
        .start_game     (start_game),
        .winner         (winner),
        .winner_valid   (winner_valid),
        .timeout_pulse  (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_hp(input int unsigned p, input logic [HP_W-1:0] v);
        hp[p*HP_W +: HP_W] = v;
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_active = 0;
        m_start  = 0;
        m_winner = 0;
        m_wvalid = 0;
        m_tpulse = 0;
        m_timer  = 0;
    endtask

    // One clock of the game rules, evaluated on the inputs present at the edge
    task automatic model_step();
        logic [NP-1:0] al;
        int cnt;
        int sole;
        int pick;
        al   = '0;
        cnt  = 0;
        sole = -1;
        pick = -1;
        for (int i = 0; i < NP; i++) begin
            if (hp[i*HP_W +: HP_W] != 0) begin
                al[i] = 1'b1;
                cnt++;
                if (sole < 0) sole = i;
            end
        end
        m_tpulse = 0;
        case (m_state)
            0: begin
                if (cnt >= 2) begin
                    for (int i = 0; i < NP; i++)
                        if (pick < 0 && enter_pressed[i] && al[i]) pick = i;
                    if (pick >= 0) begin
                        m_state  = 1;
                        m_active = pick;
                        m_start  = 1;
                        m_timer  = 0;
                    end
                end
            end
            1: begin
                if (cnt <= 1) m_state = 3;
                else if (!al[m_active] || turn_done[m_active]) m_state = 2;
                else if (TO_EN && m_timer == TT - 1) begin
                    m_state  = 2;
                    m_tpulse = 1;
                end else if (m_timer < TT) m_timer++;
            end
            2: begin
                if (cnt <= 1) m_state = 3;
                else begin
                    for (int k = 1; k < NP; k++)
                        if (pick < 0 && al[(m_active + k) % NP]) pick = (m_active + k) % NP;
                    m_active = pick;
                    m_state  = 1;
                    m_timer  = 0;
                end
            end
            default: begin
                if (enter_pressed != '0) begin
                    m_state  = 0;
                    m_start  = 0;
                    m_wvalid = 0;
                end
            end
        endcase
        if (m_state == 3) begin
            if (cnt == 1) begin
                m_winner = sole;
                m_wvalid = 1;
            end else begin
                m_wvalid = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [NP-1:0] exp_oh;
        exp_oh = (m_state == 1) ? NP'(1) << m_active : '0;
        check("state",  32'(state_game_fsm), 32'(m_state));
        check("onehot", 32'(turn_onehot),    32'(exp_oh));
        check("active", 32'(active_player),  32'(m_active));
        check("start",  32'(start_game),     32'(m_start));
        check("winner", 32'(winner),         32'(m_winner));
        check("wvalid", 32'(winner_valid),   32'(m_wvalid));
        check("tpulse", 32'(timeout_pulse),  32'(m_tpulse));
    endtask

    // Clock once with the current inputs, compare, then clear input pulses
    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        compare_all();
        @(negedge clk);
        enter_pressed = '0;
        turn_done     = '0;
    endtask

    initial begin
        rst           = 1'b1;
        enter_pressed = '0;
        turn_done     = '0;
        for (int i = 0; i < NP; i++) set_hp(i, 10'd100);
        model_reset();

        // Reset values
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_state",  32'(state_game_fsm), 32'd0);
        check("rst_onehot", 32'(turn_onehot),    32'd0);
        check("rst_active", 32'(active_player),  32'd0);
        check("rst_start",  32'(start_game),     32'd0);
        check("rst_wvalid", 32'(winner_valid),   32'd0);
        check("rst_tpulse", 32'(timeout_pulse),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Simultaneous enter: lowest index wins, TURN after one cycle
        enter_pressed = 4'b0110;
        step();
        check("d1_state",  32'(state_game_fsm), 32'd1);
        check("d1_onehot", 32'(turn_onehot),    32'b0010);
        check("d1_active", 32'(active_player),  32'd1);
        check("d1_start",  32'(start_game),     32'd1);

        // turn_done from a non-active player is ignored
        turn_done = 4'b0101;
        step();
        check("d2_state", 32'(state_game_fsm), 32'd1);

        // Normal hand-over takes two cycles
        turn_done = 4'b0010;
        step();
        check("d3_resolve", 32'(state_game_fsm), 32'd2);
        check("d3_oh_off",  32'(turn_onehot),    32'd0);
        step();
        check("d3_onehot", 32'(turn_onehot), 32'b0100);

        // Skip dead player 3 and wrap to player 0
        set_hp(3, 10'd0);
        turn_done = 4'b0100;
        step();
        step();
        check("d4_onehot", 32'(turn_onehot),   32'b0001);
        check("d4_active", 32'(active_player), 32'd0);

        // Active player and another die: one survivor wins immediately
        set_hp(0, 10'd0);
        set_hp(1, 10'd0);
        turn_done = 4'b0001;
        step();
        check("d5_state",  32'(state_game_fsm), 32'd3);
        check("d5_winner", 32'(winner),         32'd2);
        check("d5_wvalid", 32'(winner_valid),   32'd1);
        check("d5_onehot", 32'(turn_onehot),    32'd0);

        // Everyone dead: draw, winner index retained
        set_hp(2, 10'd0);
        step();
        check("d6_wvalid", 32'(winner_valid), 32'd0);
        check("d6_winner", 32'(winner),       32'd2);

        // Enter leaves GAME_OVER
        enter_pressed = 4'b1000;
        step();
        check("d7_state", 32'(state_game_fsm), 32'd0);
        check("d7_start", 32'(start_game),     32'd0);

        // Enter ignored with fewer than two alive
        set_hp(3, 10'd100);
        enter_pressed = 4'b1000;
        step();
        check("d8_state", 32'(state_game_fsm), 32'd0);

        // Enter from a dead player is ignored
        set_hp(1, 10'd55);
        enter_pressed = 4'b0001;
        step();
        check("d9_state", 32'(state_game_fsm), 32'd0);

        // Dead presser skipped in favour of the alive one
        enter_pressed = 4'b1001;
        step();
        check("d10_active", 32'(active_player), 32'd3);
        check("d10_onehot", 32'(turn_onehot),   32'b1000);

        turn_done = 4'b1000;
        step();
        step();
        check("d11_wrap", 32'(active_player), 32'd1);

        // Active player dies with others alive: plain hand-over
        set_hp(0, 10'd9);
        set_hp(2, 10'd9);
        set_hp(1, 10'd0);
        step();
        check("d12_resolve", 32'(state_game_fsm), 32'd2);
        step();
        check("d12_active", 32'(active_player), 32'd2);

        // Asynchronous reset mid-turn clears before the next edge
        step();
        #2;
        rst = 1'b1;
        #1;
        check("ar_state",  32'(state_game_fsm), 32'd0);
        check("ar_onehot", 32'(turn_onehot),    32'd0);
        check("ar_active", 32'(active_player),  32'd0);
        check("ar_start",  32'(start_game),     32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NP; i++) set_hp(i, 10'd100);

        enter_pressed = 4'b0001;
        step();
`ifdef TURN_TIMEOUT_EN
        // Forfeit after TT cycles without turn_done
        for (int i = 0; i < int'(TT) - 1; i++) begin
            step();
            check("to_wait", 32'(timeout_pulse), 32'd0);
        end
        step();
        check("to_pulse", 32'(timeout_pulse),  32'd1);
        check("to_state", 32'(state_game_fsm), 32'd2);
        step();
        check("to_clear", 32'(timeout_pulse), 32'd0);
        check("to_next",  32'(active_player), 32'd1);
        // turn_done on the deadline cycle counts as a normal done
        for (int i = 0; i < int'(TT) - 1; i++) step();
        turn_done = 4'b0010;
        step();
        check("to_done_nopulse", 32'(timeout_pulse),  32'd0);
        check("to_done_state",   32'(state_game_fsm), 32'd2);
        step();
        check("to_done_next", 32'(active_player), 32'd2);
`else
        // Without the timer a turn never expires
        for (int i = 0; i < 30; i++) step();
        check("nt_state",  32'(state_game_fsm), 32'd1);
        check("nt_tpulse", 32'(timeout_pulse),  32'd0);
`endif

        // Randomized play against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) enter_pressed = NP'($urandom);
            if ($urandom_range(0, 3) == 0) turn_done = NP'($urandom);
            if ($urandom_range(0, 29) == 0) set_hp($urandom_range(0, NP - 1), 10'd0);
            if ($urandom_range(0, 39) == 0)
                set_hp($urandom_range(0, NP - 1), HP_W'($urandom_range(0, 1023)));
            if ((m_state == 3 || m_state == 0) && $urandom_range(0, 7) == 0)
                for (int i = 0; i < NP; i++) set_hp(i, HP_W'($urandom_range(1, 1023)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
